// File: rtl/edgetracing_mul_pkg.sv
// ---------------------------------------------------------------------------
// edgetracing_mul_pkg
// Shared definitions for the edge-tracing multiplier arbiter:
//   - default operand/product widths and multiplier latency
//   - tag_t: {valid, id} carried alongside each multiplier operation
//   - rr_pick_t / rr_search(): round-robin first-set-bit search
// ---------------------------------------------------------------------------
package edgetracing_mul_pkg;

  localparam int unsigned DEF_A_W     = 13;
  localparam int unsigned DEF_B_W     = 11;
  localparam int unsigned DEF_P_W     = DEF_A_W + DEF_B_W;
  localparam int unsigned DEF_MUL_LAT = 3;

  // Upper bound on requesters; ids are stored at this width everywhere.
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic                found;
    logic [ID_MAX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] at or after ptr, wrapping modulo n.
  // ptr must be < n.
  function automatic rr_pick_t rr_search(input logic [MAX_REQ-1:0]  req,
                                         input logic [ID_MAX_W-1:0] ptr,
                                         input int unsigned         n);
    rr_pick_t    pick;
    int unsigned idx;
    pick = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) begin
        idx = idx - n;
      end
      if ((k < n) && (idx < MAX_REQ) && !pick.found && req[idx]) begin
        pick.found = 1'b1;
        pick.idx   = ID_MAX_W'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/edgetracing_mul_tag_pipe.sv
// ---------------------------------------------------------------------------
// edgetracing_mul_tag_pipe
// Clock-enabled {valid, id} shift register that tracks which requester owns
// each operation inside the shared multiplier. Only the valid bits are reset;
// ids are meaningless while their valid bit is low.
// Ports:
//   clk, reset   clock / asynchronous active-high reset
//   i_ce         shift enable (frozen while low)
//   i_tag        tag entering stage 0
//   o_tag_last   tag at the last stage (aligned with multiplier output)
//   o_valid      valid bit of every stage
// ---------------------------------------------------------------------------
module edgetracing_mul_tag_pipe
  import edgetracing_mul_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_ce,
  input  tag_t             i_tag,
  output tag_t             o_tag_last,
  output logic [DEPTH-1:0] o_valid
);

  logic [DEPTH-1:0]    r_valid;
  logic [ID_MAX_W-1:0] r_id [DEPTH];

  // Valid bits: reset clears every in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_ce) begin
      r_valid[0] <= i_tag.valid;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1];
      end
    end
  end

  // Ids: no reset needed.
  always_ff @(posedge clk) begin
    if (i_ce) begin
      r_id[0] <= i_tag.id;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        r_id[s] <= r_id[s-1];
      end
    end
  end

  assign o_valid          = r_valid;
  assign o_tag_last.valid = r_valid[DEPTH-1];
  assign o_tag_last.id    = r_id[DEPTH-1];

endmodule

// File: rtl/edgetracing_mul_arbiter.sv
// ---------------------------------------------------------------------------
// edgetracing_mul_arbiter
// Shares one external pipelined unsigned multiplier (MUL_LAT register stages,
// clock-enabled) among NUM_REQ requesters. One request is granted per
// non-stalled cycle, its operands are registered into the multiplier and its
// id travels in a tag pipeline so the product is steered back with a one-hot
// valid. A downstream stall freezes the whole datapath.
//
// Optional feature macro: EDGETRACING_MUL_ARB_PRIO0_EN
//   defined   - requester 0 has strict priority (rr pointer untouched by its
//               grants); requesters 1..NUM_REQ-1 round-robin among themselves
//   undefined - plain round-robin across all requesters
//
// Ports:
//   clk, reset    clock / asynchronous active-high reset
//   i_req_valid   per-requester request
//   i_req_a/b     packed operands, requester i at [i*W +: W]
//   o_req_ready   one-hot grant (combinational)
//   i_stall       downstream hold
//   o_mul_ce      multiplier clock enable (= ~i_stall)
//   o_mul_din0/1  registered operands to the multiplier
//   i_mul_dout    multiplier product
//   o_rsp_valid   one-hot result valid (combinational)
//   o_rsp_p       product, shared by all requesters
//   o_busy        any operation in flight
// ---------------------------------------------------------------------------
module edgetracing_mul_arbiter
  import edgetracing_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned A_W     = DEF_A_W,
  parameter int unsigned B_W     = DEF_B_W,
  parameter int unsigned P_W     = DEF_P_W,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [NUM_REQ*A_W-1:0] i_req_a,
  input  logic [NUM_REQ*B_W-1:0] i_req_b,
  output logic [NUM_REQ-1:0]     o_req_ready,
  input  logic                   i_stall,
  output logic                   o_mul_ce,
  output logic [A_W-1:0]         o_mul_din0,
  output logic [B_W-1:0]         o_mul_din1,
  input  logic [P_W-1:0]         i_mul_dout,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  output logic [P_W-1:0]         o_rsp_p,
  output logic                   o_busy
);

  localparam int unsigned TAG_DEPTH = MUL_LAT + 1;

  logic                 w_ce;
  rr_pick_t             w_pick;
  logic                 w_grant;
  logic                 w_ptr_upd;
  logic [ID_MAX_W-1:0]  w_next_ptr;
  logic [A_W-1:0]       w_sel_a;
  logic [B_W-1:0]       w_sel_b;
  tag_t                 w_tag_in;
  tag_t                 w_tag_last;
  logic [TAG_DEPTH-1:0] w_tag_valid;

  logic [ID_MAX_W-1:0]  r_rr_ptr;
  logic [A_W-1:0]       r_mul_din0;
  logic [B_W-1:0]       r_mul_din1;

  assign w_ce     = ~i_stall;
  assign o_mul_ce = w_ce;

  // Requester selection.
  always_comb begin
    w_pick = '0;
`ifdef EDGETRACING_MUL_ARB_PRIO0_EN
    if (i_req_valid[0]) begin
      w_pick.found = 1'b1;
      w_pick.idx   = '0;
    end else begin
      w_pick = rr_search(MAX_REQ'(i_req_valid) & ~MAX_REQ'(1), r_rr_ptr, NUM_REQ);
    end
`else
    w_pick = rr_search(MAX_REQ'(i_req_valid), r_rr_ptr, NUM_REQ);
`endif
  end

  // Reset gates the grant so req_ready drops as soon as reset asserts.
  assign w_grant = w_pick.found & w_ce & ~reset;

  always_comb begin
    o_req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      o_req_ready[i] = w_grant && (w_pick.idx == ID_MAX_W'(i));
    end
  end

  assign w_sel_a = i_req_a[32'(w_pick.idx)*A_W +: A_W];
  assign w_sel_b = i_req_b[32'(w_pick.idx)*B_W +: B_W];

  // Pointer moves past the granted requester; a priority grant to 0 leaves it.
`ifdef EDGETRACING_MUL_ARB_PRIO0_EN
  assign w_ptr_upd = w_grant && (w_pick.idx != '0);
`else
  assign w_ptr_upd = w_grant;
`endif
  assign w_next_ptr = ((32'(w_pick.idx) + 1) >= NUM_REQ) ? '0
                                                         : ID_MAX_W'(32'(w_pick.idx) + 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_ptr_upd) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

  // Issue register: operands hold when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mul_din0 <= '0;
      r_mul_din1 <= '0;
    end else if (w_grant) begin
      r_mul_din0 <= w_sel_a;
      r_mul_din1 <= w_sel_b;
    end
  end

  assign o_mul_din0 = r_mul_din0;
  assign o_mul_din1 = r_mul_din1;

  // Stage 0 of the tag pipe sits beside the issue register; the remaining
  // MUL_LAT stages mirror the multiplier's internal registers.
  assign w_tag_in.valid = w_grant;
  assign w_tag_in.id    = w_pick.idx;

  edgetracing_mul_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .i_ce       (w_ce),
    .i_tag      (w_tag_in),
    .o_tag_last (w_tag_last),
    .o_valid    (w_tag_valid)
  );

  // A result is delivered once, in the first non-stalled cycle it is present.
  always_comb begin
    o_rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      o_rsp_valid[i] = w_tag_last.valid && (w_tag_last.id == ID_MAX_W'(i)) && w_ce;
    end
  end

  assign o_rsp_p = i_mul_dout;
  assign o_busy  = |w_tag_valid;

endmodule

// File: tb/tb_edgetracing_mul_arbiter.sv
module tb_edgetracing_mul_arbiter;

  localparam int N   = 4;
  localparam int AW  = 13;
  localparam int BW  = 11;
  localparam int PW  = 24;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic            stall;
  logic            mul_ce;
  logic [AW-1:0]   mul_din0;
  logic [BW-1:0]   mul_din1;
  logic [PW-1:0]   mul_dout;
  logic [N-1:0]    rsp_valid;
  logic [PW-1:0]   rsp_p;
  logic            busy;

  logic [AW-1:0] a_v [N];
  logic [BW-1:0] b_v [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = a_v[i];
      req_b[i*BW +: BW] = b_v[i];
    end
  end

  always #5 clk = ~clk;

  edgetracing_mul_arbiter #(
    .NUM_REQ (N), .A_W (AW), .B_W (BW), .P_W (PW), .MUL_LAT (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (req_valid),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_req_ready (req_ready),
    .i_stall     (stall),
    .o_mul_ce    (mul_ce),
    .o_mul_din0  (mul_din0),
    .o_mul_din1  (mul_din1),
    .i_mul_dout  (mul_dout),
    .o_rsp_valid (rsp_valid),
    .o_rsp_p     (rsp_p),
    .o_busy      (busy)
  );

  // External multiplier: LAT clock-enabled register stages.
  logic [PW-1:0] m_s [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      m_s[0] <= PW'(mul_din0) * PW'(mul_din1);
      for (int s = 1; s < LAT; s++) m_s[s] <= m_s[s-1];
    end
  end
  assign mul_dout = m_s[LAT-1];

  // Scoreboard entry: owner, product and the enabled-cycle count at which
  // the result is due.
  typedef struct {
    int          id;
    logic [PW-1:0] p;
    int          due;
  } exp_t;

  exp_t         sb[$];
  int           rr_m       = 0;
  int           ce_count   = 0;
  bit           in_rst     = 1'b1;
  logic [N-1:0] last_ready = '0;
  int           n_checks   = 0;
  int           n_errors   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Predictor: reference arbitration from the current inputs; pushes the
  // expected result of every grant.
  initial begin : predictor
    int           g;
    int           j;
    logic [N-1:0] exp_ready;
    exp_t         e;
    forever begin
      @(negedge clk);
      #1;
      g = -1;
      if (!in_rst && !stall) begin
`ifdef EDGETRACING_MUL_ARB_PRIO0_EN
        if (req_valid[0]) g = 0;
`endif
        for (int k = 0; k < N; k++) begin
          j = (rr_m + k) % N;
`ifdef EDGETRACING_MUL_ARB_PRIO0_EN
          if (j == 0) continue;
`endif
          if (g < 0 && req_valid[j]) g = j;
        end
      end
      exp_ready = (g >= 0) ? (N'(1) << g) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("mul_ce", 32'(mul_ce), 32'(!stall));
      last_ready = req_ready;
      if (g >= 0) begin
        e.id  = g;
        e.p   = PW'(a_v[g]) * PW'(b_v[g]);
        e.due = ce_count + LAT + 1;
        sb.push_back(e);
`ifdef EDGETRACING_MUL_ARB_PRIO0_EN
        if (g != 0) rr_m = (g + 1) % N;
`else
        rr_m = (g + 1) % N;
`endif
      end
      if (!stall && !in_rst) ce_count++;
    end
  end

  // Monitor: compares what the DUT presents against the scoreboard head.
  initial begin : monitor
    logic [N-1:0]  exp_v;
    logic [PW-1:0] exp_p;
    bit            deliver;
    forever begin
      @(negedge clk);
      if (in_rst) begin
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
      end else begin
        exp_v   = '0;
        exp_p   = '0;
        deliver = 1'b0;
        if (sb.size() > 0 && sb[0].due == ce_count && !stall) begin
          deliver = 1'b1;
          exp_v   = N'(1) << sb[0].id;
          exp_p   = sb[0].p;
        end
        check("busy", 32'(busy), 32'(sb.size() != 0));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (deliver) begin
          check("rsp_p", 32'(rsp_p), 32'(exp_p));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    stall     = 1'b0;
    repeat (n) tick();
  endtask

  initial begin : driver
    reset     = 1'b1;
    in_rst    = 1'b1;
    stall     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (3) tick();
    check("rst_din0", 32'(mul_din0), 32'(0));
    check("rst_din1", 32'(mul_din1), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(0));
    reset  = 1'b0;
    in_rst = 1'b0;

    // All four requesters, a=i+1, b=10.
    for (int i = 0; i < N; i++) begin
      a_v[i] = AW'(i + 1);
      b_v[i] = BW'(10);
    end
    req_valid = '1;
    repeat (8) tick();
    drain(6);

    // Single requester 1 at maximum operands.
    a_v[1]    = AW'(8191);
    b_v[1]    = BW'(2047);
    req_valid = 4'b0010;
    tick();
    drain(6);

    // Requests in cycles 0 and 1, stall over cycles 2-4.
    a_v[1] = AW'(123);  b_v[1] = BW'(45);
    req_valid = 4'b0010;
    tick();
    a_v[3] = AW'(8000); b_v[3] = BW'(2000);
    req_valid = 4'b1000;
    tick();
    a_v[2] = AW'(77);   b_v[2] = BW'(1999);
    req_valid = 4'b0100;
    stall     = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    tick();
    drain(8);

    // Asynchronous reset in the middle of cycle 2 with two operations in flight.
    for (int i = 0; i < N; i++) begin
      a_v[i] = AW'(100 + i);
      b_v[i] = BW'(3 + i);
    end
    req_valid = '1;
    tick();
    tick();
    #2;
    reset  = 1'b1;
    in_rst = 1'b1;
    sb.delete();
    rr_m   = 0;
    #1;
    check("async_rsp_valid", 32'(rsp_valid), 32'(0));
    check("async_req_ready", 32'(req_ready), 32'(0));
    check("async_busy", 32'(busy), 32'(0));
    tick();
    reset  = 1'b0;
    in_rst = 1'b0;
    repeat (4) tick();
    drain(8);

    // Requesters 0 and 2 continuously.
    a_v[0] = AW'(5);   b_v[0] = BW'(6);
    a_v[2] = AW'(700); b_v[2] = BW'(800);
    req_valid = 4'b0101;
    repeat (8) tick();
    drain(6);

    // Randomised traffic with stalls; operands held until accepted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !last_ready[i])) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          a_v[i] = ($urandom_range(0, 7) == 0) ? AW'(8191) : AW'($urandom);
          b_v[i] = ($urandom_range(0, 7) == 0) ? BW'(2047) : BW'($urandom);
        end
      end
      stall = ($urandom_range(0, 4) == 0);
      tick();
    end
    drain(12);

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
